// File: rtl/exu_mdu_ysyx_23060136.sv
// RV32M multiply/divide unit for the EXU stage.
// Multiplies use a 32-step shift-add loop and divides use a 32-step restoring
// loop, both on operand magnitudes, with the sign fixed up on the last step.
// Defining YSYX_23060136_FAST_MUL_EN swaps the multiply loop for a one-cycle
// 33x33 signed multiplier. Divides always use the loop.
module exu_mdu_ysyx_23060136 (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXU_MDU_valid,
    input  logic [2:0]  EXU_MDU_op,
    input  logic [31:0] EXU_MDU_da,
    input  logic [31:0] EXU_MDU_db,
    input  logic        EXU_MDU_flush,
    output logic        EXU_MDU_ready,
    output logic        EXU_MDU_out_valid,
    input  logic        EXU_MDU_out_ready,
    output logic [31:0] EXU_MDU_result,
    output logic        EXU_MDU_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] accHi_q, accHi_d;
    logic [31:0] accLo_q, accLo_d;
    logic [31:0] operandB_q, operandB_d;
    logic        negate_q, negate_d;
    logic [31:0] result_q, result_d;

    logic        accept;
    logic        signedA, signedB, signA, signB;
    logic [31:0] magA, magB;
    logic        divByZero, divOverflow;
    logic [32:0] mulSum;
    logic [31:0] mulHi, mulLo;
    logic [32:0] divShift;
    logic        divFits;
    logic [31:0] divHi, divLo;
    logic [63:0] product, productSigned;
    logic [31:0] quotSigned, remSigned;
    logic [31:0] finalResult;

    assign EXU_MDU_ready     = (state_q == IDLE) && !EXU_MDU_flush;
    assign EXU_MDU_out_valid = (state_q == DONE);
    assign EXU_MDU_busy      = (state_q != IDLE);
    assign EXU_MDU_result    = (state_q == DONE) ? result_q : 32'd0;

    assign accept = EXU_MDU_valid && EXU_MDU_ready;

    // Operand A is signed for mulh, mulhsu, div, rem; B for mulh, div, rem.
    // Plain mul is treated as unsigned since its low word does not depend on sign.
    assign signedA = (EXU_MDU_op == 3'd1) || (EXU_MDU_op == 3'd2) ||
                     (EXU_MDU_op == 3'd4) || (EXU_MDU_op == 3'd6);
    assign signedB = (EXU_MDU_op == 3'd1) || (EXU_MDU_op == 3'd4) ||
                     (EXU_MDU_op == 3'd6);
    assign signA   = signedA && EXU_MDU_da[31];
    assign signB   = signedB && EXU_MDU_db[31];
    assign magA    = signA ? (32'd0 - EXU_MDU_da) : EXU_MDU_da;
    assign magB    = signB ? (32'd0 - EXU_MDU_db) : EXU_MDU_db;

    assign divByZero   = EXU_MDU_op[2] && (EXU_MDU_db == 32'd0);
    assign divOverflow = EXU_MDU_op[2] && !EXU_MDU_op[0] &&
                         (EXU_MDU_da == 32'h8000_0000) && (EXU_MDU_db == 32'hFFFF_FFFF);

    // One shift-add step: the multiplier sits in accLo and drains out the bottom
    // while the partial product grows into accHi.
    assign mulSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operandB_q} : 33'd0);
    assign mulHi  = mulSum[32:1];
    assign mulLo  = {mulSum[0], accLo_q[31:1]};

    // One restoring-divide step: the dividend shifts out of accLo into the
    // partial remainder in accHi and quotient bits shift back into accLo.
    assign divShift = {accHi_q, accLo_q[31]};
    assign divFits  = divShift >= {1'b0, operandB_q};
    assign divHi    = divFits ? (divShift[31:0] - operandB_q) : divShift[31:0];
    assign divLo    = {accLo_q[30:0], divFits};

    assign product       = {mulHi, mulLo};
    assign productSigned = negate_q ? (64'd0 - product) : product;
    assign quotSigned    = negate_q ? (32'd0 - divLo) : divLo;
    assign remSigned     = negate_q ? (32'd0 - divHi) : divHi;

    // Pick the architectural result out of the last loop step.
    always_comb begin
        finalResult = 32'd0;
        case (op_q)
            3'd0:          finalResult = productSigned[31:0];
            3'd1, 3'd2,
            3'd3:          finalResult = productSigned[63:32];
            3'd4, 3'd5:    finalResult = quotSigned;
            default:       finalResult = remSigned;
        endcase
    end

`ifdef YSYX_23060136_FAST_MUL_EN
    logic signed [32:0] fastA, fastB;
    logic signed [65:0] fastProduct;
    logic [31:0]        fastResult;

    assign fastA       = {signA, EXU_MDU_da};
    assign fastB       = {signB, EXU_MDU_db};
    assign fastProduct = fastA * fastB;
    assign fastResult  = (EXU_MDU_op == 3'd0) ? fastProduct[31:0] : fastProduct[63:32];
`endif

    // Next-state logic: accept and bypass decisions in IDLE, loop stepping in
    // CALC, handshake in DONE; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        count_d    = count_q;
        accHi_d    = accHi_q;
        accLo_d    = accLo_q;
        operandB_d = operandB_q;
        negate_d   = negate_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = EXU_MDU_op;
                    count_d    = 5'd0;
                    accHi_d    = 32'd0;
                    accLo_d    = magA;
                    operandB_d = magB;
                    negate_d   = (EXU_MDU_op[2] && EXU_MDU_op[1]) ? signA : (signA ^ signB);
                    if (divByZero) begin
                        result_d = EXU_MDU_op[1] ? EXU_MDU_da : 32'hFFFF_FFFF;
                        state_d  = DONE;
                    end else if (divOverflow) begin
                        result_d = EXU_MDU_op[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = DONE;
`ifdef YSYX_23060136_FAST_MUL_EN
                    end else if (!EXU_MDU_op[2]) begin
                        result_d = fastResult;
                        state_d  = DONE;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                accHi_d = op_q[2] ? divHi : mulHi;
                accLo_d = op_q[2] ? divLo : mulLo;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = finalResult;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (EXU_MDU_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (EXU_MDU_flush) begin
            state_d = IDLE;
        end
    end

    // State registers with synchronous reset clearing everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            count_q    <= 5'd0;
            accHi_q    <= 32'd0;
            accLo_q    <= 32'd0;
            operandB_q <= 32'd0;
            negate_q   <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            count_q    <= count_d;
            accHi_q    <= accHi_d;
            accLo_q    <= accLo_d;
            operandB_q <= operandB_d;
            negate_q   <= negate_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: doc/exu_mdu_ysyx_23060136.md
EXU_MDU_YSYX_23060136 -- requirements
Module: EXU_MDU_ysyx_23060136

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port EXU_MDU_valid, input, 1: request present.
REQ-004 SHALL have port EXU_MDU_op, input, 3: RV32M funct3 (0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu).
REQ-005 SHALL have ports EXU_MDU_da and EXU_MDU_db, input, 32 each: operand A (rs1) and operand B (rs2).
REQ-006 SHALL have port EXU_MDU_flush, input, 1: kill current operation.
REQ-007 SHALL have port EXU_MDU_ready, output, 1: request accepted this cycle when high with EXU_MDU_valid.
REQ-008 SHALL have port EXU_MDU_out_valid, output, 1: EXU_MDU_result holds a finished result.
REQ-009 SHALL have port EXU_MDU_out_ready, input, 1: consumer takes result.
REQ-010 SHALL have port EXU_MDU_result, output, 32: finished result.
REQ-011 SHALL have port EXU_MDU_busy, output, 1: high in any state other than IDLE; used by hazard unit to stall.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL drive EXU_MDU_ready=1 only in IDLE with EXU_MDU_flush=0.
REQ-014 Accept (valid&&ready) SHALL latch op, da, db and a 5-bit iteration counter=0; later operand changes SHALL be ignored.
REQ-015 Normal accept SHALL go IDLE->CALC; CALC SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) on magnitudes, 32 cycles, counter 0..31.
REQ-016 When counter==31, CALC SHALL move to DONE; EXU_MDU_out_valid SHALL rise exactly 33 cycles after the accept edge.
REQ-017 Signed ops SHALL take absolute values at accept and negate the final result per RISC-V sign rules (mulh signed x signed, mulhsu signed x unsigned; quotient sign = sa^sb, remainder sign = sa).
REQ-018 mul SHALL return low 32 bits of the 64-bit product; mulh/mulhsu/mulhu SHALL return high 32 bits.
REQ-019 Divide by zero SHALL bypass CALC (IDLE->DONE, out_valid next cycle): div/divu -> 0xFFFFFFFF, rem/remu -> da.
REQ-020 Signed overflow (div/rem, da=0x80000000, db=0xFFFFFFFF) SHALL bypass CALC: div -> 0x80000000, rem -> 0.
REQ-021 In DONE, EXU_MDU_out_valid and EXU_MDU_result SHALL hold stable until EXU_MDU_out_ready=1; that edge SHALL return to IDLE.
REQ-022 A new request SHALL not be accepted in the DONE->IDLE cycle; earliest re-accept is the following cycle.
REQ-023 EXU_MDU_flush=1 in any state SHALL force IDLE next edge, drop out_valid, discard the result; flush with valid in IDLE SHALL not accept.
REQ-024 EXU_MDU_result SHALL be 0 whenever EXU_MDU_out_valid=0.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, counter 0, internal registers 0, from any state including mid-CALC.
REQ-026 During and after reset: EXU_MDU_ready=1 (when rst low and no flush), out_valid=0, busy=0, result=0.
REQ-027 A request presented while rst=1 SHALL not be accepted.

Configuration
REQ-028 Macro YSYX_23060136_FAST_MUL_EN SHALL select multiply implementation.
REQ-029 Defined: mul/mulh/mulhsu/mulhu SHALL compute with a single-cycle 33x33 signed product, IDLE->DONE, out_valid 1 cycle after accept; divides unchanged.
REQ-030 Undefined: all multiplies SHALL use the 32-cycle iterative path of REQ-015/016; no hardware multiplier inferred.

Verification
REQ-031 mul da=7, db=-3 (0xFFFFFFFD), out_ready=1 -> result 0xFFFFFFEB; out_valid at accept+33 (accept+1 with FAST_MUL_EN).
REQ-032 mulhu da=db=0xFFFFFFFF -> 0xFFFFFFFE; mulh same operands -> 0x00000000.
REQ-033 div da=-20, db=3 -> 0xFFFFFFFA; rem same -> 0xFFFFFFFE; divu da=20, db=0 -> 0xFFFFFFFF at accept+1.
REQ-034 div da=0x80000000, db=0xFFFFFFFF -> 0x80000000 at accept+1; rem -> 0.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable all 5 cycles; ready=0 throughout.
REQ-036 divu accepted, flush at CALC cycle 10 -> IDLE next edge, no out_valid; repeat with rst at cycle 10 -> same, all outputs at reset values.
